fifo_queue: RTL and testbench
=============================

// Module: fifo_queue
//
// PURPOSE
//   First-in/first-out queue: the opposite-end counterpart to the LIFO stack.
//   Elements enter at the tail and leave from the head, preserving arrival order.
//   Backed by a circular buffer with read/write pointers. Used to buffer words
//   between producer and consumer blocks (e.g. UART byte streams, event queues).
//
// PARAMETERS
//   WIDTH    8   bits per element
//   DEPTH   16   number of elements; must be a power of 2, >= 2
//   ADDR_SZ  4   log2(DEPTH); pointer width
//
// PORTS
//   i_clk    in   1          system clock, all state updates on rising edge
//   i_rst    in   1          synchronous active-high reset
//   i_data   in   WIDTH      value to enqueue at tail
//   i_put    in   1          enqueue request
//   i_take   in   1          dequeue request (removes current head)
//   o_data   out  WIDTH      head-of-queue value (first-word fall-through)
//   o_empty  out  1          queue holds 0 elements
//   o_full   out  1          queue holds DEPTH elements
//   o_count  out  ADDR_SZ+1  number of elements held, 0..DEPTH
//   o_error  out  1          sticky: overflow or underflow has occurred
//
// BEHAVIOUR
//   - Reset (i_rst=1 at clock edge): rd_ptr=0, wr_ptr=0, o_count=0, o_empty=1,
//     o_full=0, o_error=0. Storage array is not cleared. Reset overrides put/take.
//   - o_data = mem[rd_ptr], combinational read; valid only while o_empty=0,
//     don't-care while empty. Written value visible on o_data the cycle after put
//     (when queue was empty). No combinational path from i_put/i_take to outputs.
//   - o_empty = (o_count==0), o_full = (o_count==DEPTH), both registered-equivalent.
//   - Pointers are ADDR_SZ bits and wrap DEPTH-1 -> 0 by natural overflow.
//   - Per clock, by {i_put, i_take} and state:
//       put only, not full : mem[wr_ptr]<=i_data, wr_ptr+1, count+1
//       put only, full     : overflow; data dropped, no state change, o_error<=1
//       take only, nonempty: rd_ptr+1, count-1
//       take only, empty   : underflow; no state change, o_error<=1
//       put+take, nonempty : both proceed (also when full); count unchanged;
//                            o_data advances to next element, new word at tail
//       put+take, empty    : put proceeds, take is underflow; count 0->1, o_error<=1
//       neither            : no change
//   - o_error stays 1 until i_rst; it never blocks further operation.
//   - Reset mid-operation discards all queued data; queue empty next cycle.
//
// TESTING
//   1. Reset, then idle -> o_empty=1, o_full=0, o_count=0, o_error=0.
//   2. Put 0x01..0x10 on 16 consecutive cycles -> o_full=1, o_count=16; then
//      take 16 cycles -> o_data reads 0x01..0x10 in order, ends o_empty=1, o_error=0.
//   3. Wrap: put 10, take 10, put 12, take 12 (values 0xA0+n) -> order preserved
//      across pointer wrap, o_count tracks exactly, o_error=0.
//   4. Full queue, put 0x55 alone -> dropped, o_count=16, o_error=1; then
//      put 0x66 + take together -> head removed, 0x66 last out, o_count stays 16.
//   5. Empty queue, take alone -> o_error=1, o_count=0; put 0x77+take on empty ->
//      o_count=1, o_data=0x77 next cycle.
//   6. Queue holding 5 items, assert i_rst with i_put=1 -> o_count=0, o_empty=1,
//      o_error=0 next cycle; subsequent put 0x99 -> o_data=0x99.

Source files
------------

// File: rtl/fifo_queue.sv
// fifo_queue: circular-buffer FIFO with first-word fall-through read port,
// element count, full/empty flags and a sticky overflow/underflow error flag.
//
// Request semantics (single comment for the whole interface):
//   i_put and i_take are sampled on the rising edge of i_clk. There is no
//   back-pressure handshake. The producer should look at o_full and the
//   consumer should look at o_empty before asserting a request.
//   A put while full is only accepted when a take happens in the same cycle.
//   Otherwise it is dropped and recorded in o_error.
//   A take while empty is never performed and is recorded in o_error.
//   o_data always shows the current head. It is meaningful only while
//   o_empty is 0.
module fifo_queue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_SZ = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_put,
  input  logic               i_take,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [ADDR_SZ:0]   o_count,
  output logic               o_error
);

  localparam logic [ADDR_SZ:0]   FULL_COUNT = (ADDR_SZ+1)'(DEPTH);
  localparam logic [ADDR_SZ:0]   CNT_ONE    = (ADDR_SZ+1)'(1);
  localparam logic [ADDR_SZ-1:0] PTR_ONE    = ADDR_SZ'(1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_SZ-1:0] rd_ptr;
  logic [ADDR_SZ-1:0] wr_ptr;
  logic [ADDR_SZ:0]   count;
  logic               error;

  logic               is_empty;
  logic               is_full;
  logic               do_put;
  logic               do_take;
  logic               bad_op;
  logic [ADDR_SZ:0]   count_next;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_COUNT);

  // Decide which halves of the request actually happen this cycle.
  // A simultaneous take frees a slot, so a put into a full queue can proceed.
  always_comb begin
    do_put     = i_put  && (!is_full || i_take);
    do_take    = i_take && !is_empty;
    bad_op     = (i_put && is_full && !i_take) || (i_take && is_empty);
    count_next = count;
    case ({do_put, do_take})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Pointer, count and sticky error state. Reset overrides any request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      error  <= 1'b0;
    end else begin
      if (do_put)  wr_ptr <= wr_ptr + PTR_ONE;
      if (do_take) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      if (bad_op) error <= 1'b1;
    end
  end

  // Storage is not cleared by reset; a write is suppressed while reset is held.
  always_ff @(posedge i_clk) begin
    if (!i_rst && do_put) mem[wr_ptr] <= i_data;
  end

  // The head word falls through combinationally from the registered read pointer.
  always_comb begin
    o_data  = mem[rd_ptr];
    o_empty = is_empty;
    o_full  = is_full;
    o_count = count;
    o_error = error;
  end

endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue: directed test of fifo_queue.
// A reference queue holds the expected contents, and a flag tracks the
// expected error state.
module tb_fifo_queue;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_SZ = 4;

  logic               i_clk;
  logic               i_rst;
  logic [WIDTH-1:0]   i_data;
  logic               i_put;
  logic               i_take;
  logic [WIDTH-1:0]   o_data;
  logic               o_empty;
  logic               o_full;
  logic [ADDR_SZ:0]   o_count;
  logic               o_error;

  logic [WIDTH-1:0]   exp_q[$];
  logic               m_err;
  int                 tests_run;
  int                 tests_failed;

  fifo_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_SZ(ADDR_SZ)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_put   (i_put),
    .i_take  (i_take),
    .o_data  (o_data),
    .o_empty (o_empty),
    .o_full  (o_full),
    .o_count (o_count),
    .o_error (o_error)
  );

  // Clock generation.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every status output against the reference model.
  task automatic check_status(input string tag);
    chk({tag, "/count"}, 32'(o_count), 32'(exp_q.size()));
    chk({tag, "/empty"}, 32'(o_empty), 32'(exp_q.size() == 0));
    chk({tag, "/full"},  32'(o_full),  32'(exp_q.size() == DEPTH));
    chk({tag, "/error"}, 32'(o_error), 32'(m_err));
    if (exp_q.size() != 0) chk({tag, "/head"}, 32'(o_data), 32'(exp_q[0]));
  endtask

  // Drive one cycle of requests and update the reference model.
  task automatic cycle(input logic put, input logic take, input logic [WIDTH-1:0] data);
    bit full_now;
    bit empty_now;
    i_put  = put;
    i_take = take;
    i_data = data;
    #1;
    full_now  = (exp_q.size() == DEPTH);
    empty_now = (exp_q.size() == 0);
    if (take && !empty_now) begin
      chk("take_data", 32'(o_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (put && (!full_now || take)) exp_q.push_back(data);
    if ((put && full_now && !take) || (take && empty_now)) m_err = 1'b1;
    @(posedge i_clk);
    #1;
    i_put  = 1'b0;
    i_take = 1'b0;
  endtask

  task automatic do_reset(input logic put_during);
    i_rst  = 1'b1;
    i_put  = put_during;
    i_take = 1'b0;
    i_data = 8'hEE;
    @(posedge i_clk);
    #1;
    i_rst  = 1'b0;
    i_put  = 1'b0;
    exp_q.delete();
    m_err  = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_err        = 1'b0;
    i_rst        = 1'b1;
    i_put        = 1'b0;
    i_take       = 1'b0;
    i_data       = '0;
    @(posedge i_clk);
    #1;

    // 1: reset then idle
    do_reset(1'b0);
    check_status("reset");
    cycle(1'b0, 1'b0, '0);
    check_status("idle");

    // 2: fill with 0x01..0x10, then drain in order
    for (int n = 1; n <= DEPTH; n++) cycle(1'b1, 1'b0, WIDTH'(n));
    check_status("filled");
    chk("filled_full", 32'(o_full), 32'd1);
    for (int n = 0; n < DEPTH; n++) cycle(1'b0, 1'b1, '0);
    check_status("drained");

    // 3: pointer wrap
    for (int n = 0; n < 10; n++) begin
      cycle(1'b1, 1'b0, WIDTH'(8'hA0 + n));
      chk("wrap_cnt_a", 32'(o_count), 32'(exp_q.size()));
    end
    for (int n = 0; n < 10; n++) cycle(1'b0, 1'b1, '0);
    check_status("wrap_mid");
    for (int n = 0; n < 12; n++) begin
      cycle(1'b1, 1'b0, WIDTH'(8'hA0 + n));
      chk("wrap_cnt_b", 32'(o_count), 32'(exp_q.size()));
    end
    for (int n = 0; n < 12; n++) cycle(1'b0, 1'b1, '0);
    check_status("wrap_end");

    // 4: overflow, then put+take on a full queue
    for (int n = 0; n < DEPTH; n++) cycle(1'b1, 1'b0, WIDTH'(8'h30 + n));
    cycle(1'b1, 1'b0, 8'h55);
    check_status("overflow");
    chk("overflow_err", 32'(o_error), 32'd1);
    cycle(1'b1, 1'b1, 8'h66);
    check_status("full_put_take");
    chk("full_pt_cnt", 32'(o_count), 32'd16);
    for (int n = 0; n < DEPTH - 1; n++) cycle(1'b0, 1'b1, '0);
    chk("last_out", 32'(o_data), 32'h66);
    cycle(1'b0, 1'b1, '0);
    check_status("drain4");

    // 5: underflow, then put+take on an empty queue
    do_reset(1'b0);
    cycle(1'b0, 1'b1, '0);
    check_status("underflow");
    chk("underflow_err", 32'(o_error), 32'd1);
    cycle(1'b1, 1'b1, 8'h77);
    check_status("empty_put_take");
    chk("ept_data", 32'(o_data), 32'h77);
    cycle(1'b0, 1'b1, '0);

    // 6: reset mid-operation with a put pending
    for (int n = 0; n < 5; n++) cycle(1'b1, 1'b0, WIDTH'($urandom_range(0, 255)));
    check_status("five");
    do_reset(1'b1);
    check_status("mid_reset");
    cycle(1'b1, 1'b0, 8'h99);
    check_status("after_reset");
    chk("after_reset_data", 32'(o_data), 32'h99);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
